result_emitter: RTL

RESULT_EMITTER -- requirements
Module: result_emitter

---
 rtl/result_emitter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/result_emitter.sv
// result_emitter: converts a 16-bit result to decimal ASCII by repeated subtraction and streams it
// over a valid/ready byte sink, terminated by '#'. Define SIGNED_RESULT_EN for two's-complement input.
module result_emitter (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] result,
  output logic [7:0]  out_char,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CONV = 3'd1,
    S_EMIT = 3'd2,
    S_TERM = 3'd3,
    S_FIN  = 3'd4
  } state_t;

  typedef logic [4:0][3:0] digits_t;

  localparam logic [7:0] CH_MINUS = 8'h2D;
  localparam logic [7:0] CH_TERM  = 8'h23;
  localparam logic [7:0] CH_ZERO  = 8'h30;

  function automatic logic [16:0] pow10(input logic [2:0] i);
    logic [16:0] p;
    case (i)
      3'd0:    p = 17'd1;
      3'd1:    p = 17'd10;
      3'd2:    p = 17'd100;
      3'd3:    p = 17'd1000;
      3'd4:    p = 17'd10000;
      default: p = 17'd1;
    endcase
    return p;
  endfunction

  function automatic logic [7:0] to_ascii(input logic [3:0] d);
    return CH_ZERO + {4'h0, d};
  endfunction

  // Index of the most significant nonzero digit; digit 0 when the value is zero.
  function automatic logic [2:0] msd_of(input digits_t d);
    logic [2:0] m;
    m = 3'd0;
    for (int i = 1; i < 5; i++) begin
      if (d[i] != 4'd0) m = 3'(i);
    end
    return m;
  endfunction

  state_t      state_q, state_d;
  logic [16:0] rem_q, rem_d;
  logic        neg_q, neg_d;
  logic [2:0]  idx_q, idx_d;
  digits_t     digit_q, digit_d;
  logic        sign_pend_q, sign_pend_d;
  logic [7:0]  out_char_q, out_char_d;
  logic        out_valid_q, out_valid_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic        sgn_s;
  logic [16:0] mag_s;
  logic [2:0]  msd_s;
  logic        accept_s;

`ifdef SIGNED_RESULT_EN
  // Negation at 17 bits so 16'h8000 yields 32768.
  assign sgn_s = result[15];
  assign mag_s = result[15] ? (17'd0 - {1'b1, result}) : {1'b0, result};
`else
  assign sgn_s = 1'b0;
  assign mag_s = {1'b0, result};
`endif

  assign msd_s    = msd_of(digit_q);
  assign accept_s = out_valid_q & out_ready;

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    neg_d       = neg_q;
    idx_d       = idx_q;
    digit_d     = digit_q;
    sign_pend_d = sign_pend_q;
    out_char_d  = out_char_q;
    out_valid_d = out_valid_q;
    case (state_q)
      S_IDLE: begin
        out_valid_d = 1'b0;
        if (start) begin
          rem_d   = mag_s;
          neg_d   = sgn_s;
          digit_d = '0;
          idx_d   = 3'd4;
          state_d = S_CONV;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONV: begin
        if (rem_q >= pow10(idx_q)) begin
          rem_d          = rem_q - pow10(idx_q);
          digit_d[idx_q] = digit_q[idx_q] + 4'd1;
        end else if (idx_q == 3'd0) begin
          state_d     = S_EMIT;
          out_valid_d = 1'b1;
          idx_d       = msd_s;
          sign_pend_d = neg_q;
          out_char_d  = neg_q ? CH_MINUS : to_ascii(digit_q[msd_s]);
        end else begin
          idx_d = idx_q - 3'd1;
        end
      end
      S_EMIT: begin
        if (!accept_s) begin
          state_d = S_EMIT;
        end else if (sign_pend_q) begin
          sign_pend_d = 1'b0;
          out_char_d  = to_ascii(digit_q[idx_q]);
        end else if (idx_q == 3'd0) begin
          state_d    = S_TERM;
          out_char_d = CH_TERM;
        end else begin
          idx_d      = idx_q - 3'd1;
          out_char_d = to_ascii(digit_q[idx_q - 3'd1]);
        end
      end
      S_TERM: begin
        if (accept_s) begin
          state_d     = S_FIN;
          out_valid_d = 1'b0;
          out_char_d  = 8'h00;
        end else begin
          state_d = S_TERM;
        end
      end
      S_FIN: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
      default: begin
        out_valid_d = 1'b0;
        state_d     = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_FIN);
  end

  // State and output registers; reset applies immediately, even mid-transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rem_q       <= 17'd0;
      neg_q       <= 1'b0;
      idx_q       <= 3'd0;
      digit_q     <= '0;
      sign_pend_q <= 1'b0;
      out_char_q  <= 8'h00;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      neg_q       <= neg_d;
      idx_q       <= idx_d;
      digit_q     <= digit_d;
      sign_pend_q <= sign_pend_d;
      out_char_q  <= out_char_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign out_char  = out_char_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
